// File: rtl/fire_pkg.sv
// Shared types and constants for the fire-module expand sequencer.
// Optional stall counter is enabled by defining FIRE_CTRL_PERF_EN.
package fire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    EMIT,
    FIN
  } fire_ctrl_state_t;

  localparam int FIRE_DRAIN_CYC = 2;
  localparam int FIRE_MAC_LAT   = 1;

  function automatic int fire_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fire_wrap_ctr.sv
// Up-counter with enable, synchronous clear and wrap strobe.
// Used for the channel, pixel and pass indices.
module fire_wrap_ctr #(
  parameter int MAX = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fire_ex_ctrl.sv
// Sequencer for the fire 1x1 expand datapath (MAC, weight ROM, ofm).
// Define FIRE_CTRL_PERF_EN to build the stall_cnt performance counter.
module fire_ex_ctrl
  import fire_pkg::*;
#(
  parameter  int CHIN   = 32,
  parameter  int PIXELS = 1024,
  parameter  int PASSES = 1,
  localparam int AW     = fire_w(CHIN * PASSES),
  localparam int PW     = fire_w(PIXELS),
  localparam int SW     = fire_w(PASSES),
  localparam int CW     = fire_w(CHIN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          ifm_valid,
  output logic          ifm_rd_en,
  output logic [AW-1:0] w_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          ofm_valid,
  input  logic          ofm_ready,
  output logic [PW-1:0] ofm_pix,
  output logic [SW-1:0] ofm_pass,
  output logic [31:0]   stall_cnt
);

  fire_ctrl_state_t state, state_nx;

  logic [CW-1:0] ch;
  logic [PW-1:0] pix;
  logic [SW-1:0] pass;
  logic          ch_wrap;
  logic          pix_wrap;
  logic          pass_wrap;
  logic          go;
  logic          rd;
  logic          hs;
  logic [1:0]    drain;

  logic [FIRE_MAC_LAT-1:0] rd_d;
  logic [FIRE_MAC_LAT-1:0] clr_d;

  assign go = (state == IDLE) && start;
  assign rd = (state == ACCUM) && ifm_valid;
  assign hs = (state == EMIT) && ofm_ready;

  fire_wrap_ctr #(.MAX(CHIN), .W(CW)) u_ch (
    .clk  (clk),
    .rst  (rst),
    .clr  (go || hs),
    .en   (rd),
    .cnt  (ch),
    .wrap (ch_wrap)
  );

  fire_wrap_ctr #(.MAX(PIXELS), .W(PW)) u_pix (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .en   (hs),
    .cnt  (pix),
    .wrap (pix_wrap)
  );

  fire_wrap_ctr #(.MAX(PASSES), .W(SW)) u_pass (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .en   (pix_wrap),
    .cnt  (pass),
    .wrap (pass_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = ACCUM;
      ACCUM: if (ch_wrap) state_nx = DRAIN;
      DRAIN: begin
        if (drain == 2'(FIRE_DRAIN_CYC - 1)) begin
          state_nx = EMIT;
        end
      end
      EMIT: begin
        if (hs) state_nx = pass_wrap ? FIN : ACCUM;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // MAC enables follow the read strobe by the buffer read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain <= '0;
      rd_d  <= '0;
      clr_d <= '0;
      done  <= 1'b0;
    end else begin
      drain <= (state == DRAIN) ? drain + 2'd1 : 2'd0;
      rd_d  <= FIRE_MAC_LAT'({rd_d, rd});
      clr_d <= FIRE_MAC_LAT'({clr_d, rd && (ch == '0)});
      done  <= (state == FIN);
    end
  end

  assign busy      = (state != IDLE);
  assign ifm_rd_en = rd;
  assign mac_en    = rd_d[FIRE_MAC_LAT-1];
  assign mac_clr   = clr_d[FIRE_MAC_LAT-1];
  assign ofm_valid = (state == EMIT);
  assign ofm_pix   = pix;
  assign ofm_pass  = pass;
  assign w_addr    = AW'(int'(pass) * CHIN + int'(ch));

`ifdef FIRE_CTRL_PERF_EN
  logic stall;

  assign stall = ((state == ACCUM) && !ifm_valid) ||
                 ((state == EMIT) && !ofm_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (go) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fire_ex_ctrl.sv
// Self-checking bench for fire_ex_ctrl: directed stalls/reset on the
// default build plus a randomized small-geometry run against a model.
module tb_fire_ex_ctrl;

  logic clk;
  logic rst;

  logic       a_start, a_busy, a_done, a_iv, a_rd;
  logic       a_men, a_mclr, a_ov, a_rdy;
  logic [4:0] a_wa;
  logic [9:0] a_pix;
  logic [0:0] a_ps;
  logic [31:0] a_sc;

  logic       b_start, b_busy, b_done, b_iv, b_rd;
  logic       b_men, b_mclr, b_ov, b_rdy;
  logic [2:0] b_wa;
  logic [1:0] b_pix;
  logic [0:0] b_ps;
  logic [31:0] b_sc;

  int n_chk;
  int n_fail;

  int m_run, m_bpix, m_wait, m_res, m_cyc;
  int m_done_at, m_stall, m_prev_rd, m_prev_clr;

  fire_ex_ctrl u_a (
    .clk       (clk),
    .rst       (rst),
    .start     (a_start),
    .busy      (a_busy),
    .done      (a_done),
    .ifm_valid (a_iv),
    .ifm_rd_en (a_rd),
    .w_addr    (a_wa),
    .mac_en    (a_men),
    .mac_clr   (a_mclr),
    .ofm_valid (a_ov),
    .ofm_ready (a_rdy),
    .ofm_pix   (a_pix),
    .ofm_pass  (a_ps),
    .stall_cnt (a_sc)
  );

  fire_ex_ctrl #(.CHIN(4), .PIXELS(4), .PASSES(2)) u_b (
    .clk       (clk),
    .rst       (rst),
    .start     (b_start),
    .busy      (b_busy),
    .done      (b_done),
    .ifm_valid (b_iv),
    .ifm_rd_en (b_rd),
    .w_addr    (b_wa),
    .mac_en    (b_men),
    .mac_clr   (b_mclr),
    .ofm_valid (b_ov),
    .ofm_ready (b_rdy),
    .ofm_pix   (b_pix),
    .ofm_pass  (b_ps),
    .stall_cnt (b_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_run      = 1;
    m_bpix     = 0;
    m_wait     = 0;
    m_res      = 0;
    m_cyc      = 0;
    m_done_at  = -1;
    m_stall    = 0;
    m_prev_rd  = 0;
    m_prev_clr = 0;
  endtask

  // One sampled cycle of the layer: CHIN beats per pixel, results
  // three cycles after the last beat, done two cycles after the last
  // accepted result.
  task automatic m_step(input string id,
                        input int chin, input int pixn,
                        input int passn,
                        input logic iv, input logic rdy,
                        input logic rd, input logic men,
                        input logic mclr, input logic ov,
                        input logic dn, input int wa,
                        input int px, input int ps);
    logic erd, eov;
    m_cyc++;
    erd = (m_run != 0) && (m_bpix < chin) && iv;
    eov = (m_run != 0) && (m_bpix == chin) && (m_wait >= 2);
    chk({id, "_rd_en"}, rd, erd);
    chk({id, "_mac_en"}, men, m_prev_rd != 0);
    chk({id, "_mac_clr"}, mclr, m_prev_clr != 0);
    chk({id, "_ofm_valid"}, ov, eov);
    chk({id, "_done"}, dn, m_cyc == m_done_at);
    if (erd) begin
      chk({id, "_w_addr"}, wa,
          m_bpix + chin * (m_res / pixn));
    end
    if (eov) begin
      chk({id, "_ofm_pix"}, px, m_res % pixn);
      chk({id, "_ofm_pass"}, ps, m_res / pixn);
    end
    if ((m_run != 0) &&
        (((m_bpix < chin) && !iv) || (eov && !rdy))) begin
      m_stall++;
    end
    m_prev_rd  = erd ? 1 : 0;
    m_prev_clr = (erd && (m_bpix == 0)) ? 1 : 0;
    if (erd) begin
      m_bpix++;
      if (m_bpix == chin) m_wait = 0;
    end else if (eov && rdy) begin
      m_res++;
      m_bpix = 0;
      m_wait = 0;
      if (m_res == pixn * passn) begin
        m_run     = 0;
        m_done_at = m_cyc + 2;
      end
    end else if (m_bpix == chin) begin
      m_wait++;
    end
  endtask

  initial begin
    int seen, dk, ndone;
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b0;
    a_start = 1'b1;
    a_iv    = 1'b1;
    a_rdy   = 1'b1;
    b_start = 1'b1;
    b_iv    = 1'b0;
    b_rdy   = 1'b0;
    m_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_rd_en", a_rd, 1'b0);
    chk("rst_mac_en", a_men, 1'b0);
    chk("rst_mac_clr", a_mclr, 1'b0);
    chk("rst_ofm_valid", a_ov, 1'b0);
    chk("rst_w_addr", a_wa, 0);
    chk("rst_ofm_pix", a_pix, 0);
    chk("rst_ofm_pass", a_ps, 0);
    chk("rst_stall_cnt", a_sc, 0);
    chk("rst_b_busy", b_busy, 1'b0);
    chk("rst_b_stall_cnt", b_sc, 0);

    @(posedge clk); #1;
    rst     = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    @(negedge clk);
    chk("start_during_rst", a_busy, 1'b0);

    // Directed: input stall, output stall, start while busy, reset
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int k = 1; k <= 135; k++) begin
      a_iv    = !(k >= 11 && k <= 15);
      a_rdy   = !(k >= 75 && k <= 81);
      a_start = (k == 50);
      @(negedge clk);
      if (k == 1) begin
        chk("d_busy_k1", a_busy, 1'b1);
        chk("d_rd_k1", a_rd, 1'b1);
        chk("d_addr_k1", a_wa, 0);
        chk("d_men_k1", a_men, 1'b0);
      end
      if (k == 2) begin
        chk("d_men_k2", a_men, 1'b1);
        chk("d_mclr_k2", a_mclr, 1'b1);
        chk("d_addr_k2", a_wa, 1);
      end
      if (k == 3) chk("d_mclr_k3", a_mclr, 1'b0);
      if (k >= 11 && k <= 15) begin
        chk("d_stall_addr", a_wa, 10);
        chk("d_stall_rd", a_rd, 1'b0);
      end
      if (k == 12) chk("d_stall_men", a_men, 1'b0);
      if (k == 16) begin
        chk("d_resume_rd", a_rd, 1'b1);
        chk("d_resume_addr", a_wa, 10);
      end
      if (k == 39) chk("d_ov_early", a_ov, 1'b0);
      if (k == 40) begin
        chk("d_ov_pix0", a_ov, 1'b1);
        chk("d_pix0", a_pix, 0);
`ifdef FIRE_CTRL_PERF_EN
        chk("d_stall_cnt5", a_sc, 5);
`endif
      end
      if (k == 51) begin
        chk("d_busy_start_ign", a_busy, 1'b1);
        chk("d_addr_start_ign", a_wa, 10);
      end
      if (k >= 75 && k <= 82) begin
        chk("d_hold_ov", a_ov, 1'b1);
        chk("d_hold_pix", a_pix, 1);
        chk("d_hold_rd", a_rd, 1'b0);
      end
      if (k == 83) begin
        chk("d_after_hs_ov", a_ov, 1'b0);
        chk("d_after_hs_rd", a_rd, 1'b1);
        chk("d_after_hs_addr", a_wa, 0);
        chk("d_after_hs_pix", a_pix, 2);
`ifdef FIRE_CTRL_PERF_EN
        chk("d_stall_cnt12", a_sc, 12);
`endif
      end
      if (k == 135) begin
        chk("d_pre_rst_addr", a_wa, 17);
        chk("d_pre_rst_pix", a_pix, 3);
      end
      if (k != 135) begin
        @(posedge clk); #1;
      end
    end

    rst = 1'b0;
    #1;
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_rd", a_rd, 1'b0);
    chk("mid_rst_men", a_men, 1'b0);
    chk("mid_rst_mclr", a_mclr, 1'b0);
    chk("mid_rst_ov", a_ov, 1'b0);
    chk("mid_rst_addr", a_wa, 0);
    chk("mid_rst_pix", a_pix, 0);
    chk("mid_rst_pass", a_ps, 0);
    chk("mid_rst_sc", a_sc, 0);
    chk("mid_rst_done", a_done, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst   = 1'b1;
    a_iv  = 1'b1;
    a_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_busy", a_busy, 1'b0);
      chk("idle_rd", a_rd, 1'b0);
      @(posedge clk); #1;
    end

    // Full default layer, no stalls
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    m_reset();
    seen = 0;
    dk   = 0;
    for (int k = 1; k <= 36000 && seen == 0; k++) begin
      @(negedge clk);
      m_step("a", 32, 1024, 1, a_iv, a_rdy, a_rd, a_men,
             a_mclr, a_ov, a_done, int'(a_wa), int'(a_pix),
             int'(a_ps));
      if (a_done) begin
        seen = 1;
        dk   = k;
      end
      @(posedge clk); #1;
    end
    chk("a_done_seen", seen, 1);
    chk("a_done_latency", dk, 35842);
    chk("a_results", m_res, 1024);
`ifdef FIRE_CTRL_PERF_EN
    chk("a_stall_cnt", a_sc, m_stall);
`endif
    @(negedge clk);
    chk("a_done_single", a_done, 1'b0);
    chk("a_busy_after", a_busy, 1'b0);

    // Randomized two-pass run on the small geometry
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    m_reset();
    ndone = 0;
    for (int k = 1;
         k <= 3000 && !(m_run == 0 && m_cyc > m_done_at);
         k++) begin
      b_iv    = ($urandom_range(0, 3) != 0);
      b_rdy   = ($urandom_range(0, 2) != 0);
      b_start = (m_run != 0) && ($urandom_range(0, 9) == 0);
      @(negedge clk);
      m_step("b", 4, 4, 2, b_iv, b_rdy, b_rd, b_men,
             b_mclr, b_ov, b_done, int'(b_wa), int'(b_pix),
             int'(b_ps));
      if (b_done) ndone++;
      @(posedge clk); #1;
    end
    b_start = 1'b0;
    chk("b_results", m_res, 8);
    chk("b_done_count", ndone, 1);
    chk("b_busy_after", b_busy, 1'b0);
`ifdef FIRE_CTRL_PERF_EN
    chk("b_stall_cnt", b_sc, m_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
